// File: rtl/vga_timing_pkg.sv
// Shared VGA mode constants, monitor FSM encoding and error flag indices.
package vga_timing_pkg;

   // Default 800x600 mode, shared with the driver
   localparam int unsigned DefColorW     = 4;
   localparam int unsigned DefHActive    = 800;
   localparam int unsigned DefHFp        = 56;
   localparam int unsigned DefHSync      = 120;
   localparam int unsigned DefHBp        = 64;
   localparam int unsigned DefVActive    = 600;
   localparam int unsigned DefVFp        = 37;
   localparam int unsigned DefVSync      = 6;
   localparam int unsigned DefVBp        = 23;
   localparam int unsigned DefHTotal     = DefHActive + DefHFp + DefHSync + DefHBp;  // 1040
   localparam int unsigned DefVTotal     = DefVActive + DefVFp + DefVSync + DefVBp;  // 666
   localparam bit          DefSyncPol    = 1'b1;
   localparam int unsigned DefLockFrames = 3;

   // Monitor FSM
   typedef enum logic [1:0] {
      StSearch = 2'd0,
      StTrack  = 2'd1,
      StLocked = 2'd2
   } mon_state_e;

   // Sticky error flag positions in o_err
   localparam int unsigned ErrW      = 5;
   localparam int unsigned ErrHTotal = 0;
   localparam int unsigned ErrHSync  = 1;
   localparam int unsigned ErrVTotal = 2;
   localparam int unsigned ErrVSync  = 3;
   localparam int unsigned ErrLoss   = 4;

   // 16-bit increment that sticks at all-ones
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Sync polarity normalisation, rise/fall detection and asserted-width counter.
// With en_i tied high it measures in clocks; gated by h_rise it measures in lines.
module vga_sync_edge #(
   parameter bit SyncPol = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic        sync_i,
   output logic        rise_o,
   output logic        fall_o,
   output logic [15:0] width_o
);
   import vga_timing_pkg::*;

   logic        level;
   logic        level_q;
   logic [15:0] cnt_q;
   logic [15:0] cnt_d;
   logic [15:0] width_q;

   assign level  = (sync_i == SyncPol);
   assign rise_o = en_i & level & ~level_q;
   assign fall_o = en_i & ~level & level_q;

   // Width is presented combinationally in the fall cycle so the caller can judge it there
   assign width_o = fall_o ? cnt_q : width_q;

   // Count enabled samples while asserted; a new pulse restarts at 1
   always_comb begin
      cnt_d = cnt_q;
      if (rise_o) begin
         cnt_d = 16'd1;
      end else if (en_i && level) begin
         cnt_d = sat_inc16(cnt_q);
      end
   end

   // Registered sync level, running count and last latched width
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         level_q <= 1'b0;
         cnt_q   <= 16'd0;
         width_q <= 16'd0;
      end else begin
         if (en_i) begin
            level_q <= level;
         end
         cnt_q   <= cnt_d;
         width_q <= width_o;
      end
   end

endmodule

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: measures line/frame timing, locks after clean
// frames, raises sticky errors and reports a per-frame active-pixel checksum.
module vga_sync_monitor
   import vga_timing_pkg::*;
#(
   parameter int unsigned COLOR_W     = DefColorW,
   parameter int unsigned H_ACTIVE    = DefHActive,
   parameter int unsigned H_FP        = DefHFp,
   parameter int unsigned H_SYNC      = DefHSync,
   parameter int unsigned H_BP        = DefHBp,
   parameter int unsigned V_ACTIVE    = DefVActive,
   parameter int unsigned V_FP        = DefVFp,
   parameter int unsigned V_SYNC      = DefVSync,
   parameter int unsigned V_BP        = DefVBp,
   parameter bit          SYNC_POL    = DefSyncPol,
   parameter int unsigned LOCK_FRAMES = DefLockFrames
) (
   input  logic               clk_60Mhz,
   input  logic               reset,
   input  logic               i_h_sync,
   input  logic               i_v_sync,
   input  logic [COLOR_W-1:0] i_r,
   input  logic [COLOR_W-1:0] i_g,
   input  logic [COLOR_W-1:0] i_b,
   input  logic               i_err_clr,
   output logic               o_locked,
   output logic [ErrW-1:0]    o_err,
   output logic [15:0]        o_h_total,
   output logic [15:0]        o_v_total,
   output logic               o_frame_done,
   output logic [19:0]        o_frame_pix,
   output logic [31:0]        o_frame_sum
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned PixW    = 3 * COLOR_W;

   localparam logic [15:0] HTotal16  = 16'(H_TOTAL);
   localparam logic [15:0] VTotal16  = 16'(V_TOTAL);
   localparam logic [15:0] HSync16   = 16'(H_SYNC);
   localparam logic [15:0] VSync16   = 16'(V_SYNC);
   localparam logic [15:0] Timeout16 = 16'(2 * H_TOTAL);
   localparam logic [15:0] HActStart = 16'(H_SYNC + H_BP);
   localparam logic [15:0] HActEnd   = 16'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [15:0] VActStart = 16'(V_SYNC + V_BP);
   localparam logic [15:0] VActEnd   = 16'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [7:0]  LockCnt   = 8'(LOCK_FRAMES);

   // Sync edges
   logic        h_rise;
   logic        h_fall;
   logic [15:0] h_width;
   logic        v_rise;
   logic        v_fall;
   logic [15:0] v_width;
   logic        frame_start;

   vga_sync_edge #(
      .SyncPol (SYNC_POL)
   ) u_h_edge (
      .clk_i   (clk_60Mhz),
      .rst_i   (reset),
      .en_i    (1'b1),
      .sync_i  (i_h_sync),
      .rise_o  (h_rise),
      .fall_o  (h_fall),
      .width_o (h_width)
   );

   // v_sync is only looked at on h_rise, so its width comes out in lines
   vga_sync_edge #(
      .SyncPol (SYNC_POL)
   ) u_v_edge (
      .clk_i   (clk_60Mhz),
      .rst_i   (reset),
      .en_i    (h_rise),
      .sync_i  (i_v_sync),
      .rise_o  (v_rise),
      .fall_o  (v_fall),
      .width_o (v_width)
   );

   assign frame_start = v_rise;

   // Position counters and measurements
   logic [15:0]     h_pos_q;
   logic [15:0]     h_pos_d;
   logic [15:0]     v_line_q;
   logic [15:0]     v_line_d;
   logic [15:0]     line_period;
   logic [15:0]     frame_lines;
   logic [15:0]     h_total_q;
   logic [15:0]     v_total_q;
   logic            active;
   logic [PixW-1:0] pix_word;
   logic [19:0]     pix_cnt_q;
   logic [19:0]     pix_cnt_d;
   logic [31:0]     pix_sum_q;
   logic [31:0]     pix_sum_d;
   logic [19:0]     frame_pix_q;
   logic [31:0]     frame_sum_q;

   // Mismatch tracking for the frame in progress
   logic [3:0] mis_q;
   logic [3:0] mis_d;
   logic [3:0] mis_now;
   logic [3:0] mis_frame;
   logic       frame_good;

   // FSM and flags
   mon_state_e      state_q;
   mon_state_e      state_d;
   logic [7:0]      good_q;
   logic [7:0]      good_d;
   logic            first_q;
   logic            first_d;
   logic            timeout;
   logic            frame_done_q;
   logic            frame_done_d;
   logic [ErrW-1:0] err_q;
   logic [ErrW-1:0] err_d;
   logic [ErrW-1:0] err_set;

   assign pix_word    = {i_r, i_g, i_b};
   assign line_period = sat_inc16(h_pos_q);
   assign frame_lines = sat_inc16(v_line_q);

   // Current-cycle position, active-window decode and checksum accumulation
   always_comb begin
      h_pos_d  = h_rise ? 16'd0 : sat_inc16(h_pos_q);
      v_line_d = v_line_q;
      if (frame_start) begin
         v_line_d = 16'd0;
      end else if (h_rise) begin
         v_line_d = sat_inc16(v_line_q);
      end
      active = (h_pos_d >= HActStart) && (h_pos_d < HActEnd) &&
               (v_line_d >= VActStart) && (v_line_d < VActEnd);
      // Restart at frame_start, still counting this cycle if it happens to be active
      pix_cnt_d = (frame_start ? 20'd0 : pix_cnt_q) + {19'd0, active};
      pix_sum_d = (frame_start ? 32'd0 : pix_sum_q) + (active ? 32'(pix_word) : 32'd0);
   end

   // Per-check mismatches; the line closing at frame_start belongs to the ending frame
   always_comb begin
      mis_now            = 4'd0;
      mis_now[ErrHTotal] = h_rise & (line_period != HTotal16);
      mis_now[ErrHSync]  = h_fall & (h_width != HSync16);
      mis_now[ErrVTotal] = frame_start & (frame_lines != VTotal16);
      mis_now[ErrVSync]  = v_fall & (v_width != VSync16);
      mis_frame          = mis_q | mis_now;
      frame_good         = (mis_frame == 4'd0);
      mis_d              = frame_start ? 4'd0 : mis_frame;
   end

   // Measurement and accumulator registers
   always_ff @(posedge clk_60Mhz) begin
      if (reset) begin
         h_pos_q     <= 16'd0;
         v_line_q    <= 16'd0;
         h_total_q   <= 16'd0;
         v_total_q   <= 16'd0;
         pix_cnt_q   <= 20'd0;
         pix_sum_q   <= 32'd0;
         frame_pix_q <= 20'd0;
         frame_sum_q <= 32'd0;
         mis_q       <= 4'd0;
      end else begin
         h_pos_q   <= h_pos_d;
         v_line_q  <= v_line_d;
         pix_cnt_q <= pix_cnt_d;
         pix_sum_q <= pix_sum_d;
         mis_q     <= mis_d;
         if (h_rise) begin
            h_total_q <= line_period;
         end
         if (frame_start) begin
            v_total_q   <= frame_lines;
            frame_pix_q <= pix_cnt_q;
            frame_sum_q <= pix_sum_q;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk_60Mhz) begin
      if (reset) begin
         state_q <= StSearch;
         good_q  <= 8'd0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         good_q  <= good_d;
         first_q <= first_d;
      end
   end

   // FSM next state; first_q marks the frame right after SEARCH, which is never judged
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      first_d = first_q;
      if (timeout) begin
         state_d = StSearch;
         good_d  = 8'd0;
         first_d = 1'b0;
      end else if (frame_start) begin
         unique case (state_q)
            StSearch: begin
               state_d = StTrack;
               good_d  = 8'd0;
               first_d = 1'b1;
            end
            StTrack: begin
               if (first_q) begin
                  first_d = 1'b0;
               end else if (frame_good) begin
                  good_d = good_q + 8'd1;
                  if (good_d >= LockCnt) begin
                     state_d = StLocked;
                  end
               end else begin
                  good_d = 8'd0;
               end
            end
            StLocked: begin
               if (!frame_good) begin
                  state_d = StTrack;
                  good_d  = 8'd0;
               end
            end
            default: begin
               state_d = StSearch;
               good_d  = 8'd0;
               first_d = 1'b0;
            end
         endcase
      end
   end

   // FSM outputs: lock status, frame_done request and error set vector
   always_comb begin
      timeout      = (state_q != StSearch) && (h_pos_d >= Timeout16);
      o_locked     = (state_q == StLocked);
      frame_done_d = frame_start && (state_q != StSearch) && !first_q;
      err_set      = '0;
      if (frame_start && (state_q == StLocked)) begin
         err_set[3:0] = mis_frame;
      end
      err_set[ErrLoss] = timeout;
      // Set beats clear for the same bit
      err_d = (i_err_clr ? '0 : err_q) | err_set;
   end

   // Sticky error flags and frame_done pulse
   always_ff @(posedge clk_60Mhz) begin
      if (reset) begin
         err_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         err_q        <= err_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign o_err        = err_q;
   assign o_h_total    = h_total_q;
   assign o_v_total    = v_total_q;
   assign o_frame_done = frame_done_q;
   assign o_frame_pix  = frame_pix_q;
   assign o_frame_sum  = frame_sum_q;

endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA driver. Samples h_sync, v_sync and RGB at the pixel clock, measures the line and frame timing, and checks it against the expected mode.
- Locks after a run of clean frames and raises sticky error flags on deviations.
- Produces a per-frame active-pixel checksum so that benches and on-chip self-test can confirm what was displayed.

Parameters:
- COLOR_W, 4, bits per colour channel; pixel word = {r,g,b}, 3*COLOR_W bits.
- H_ACTIVE, 800, active pixels per line.
- H_FP, 56, horizontal front porch, clocks.
- H_SYNC, 120, h_sync width, clocks.
- H_BP, 64, horizontal back porch, clocks.
- V_ACTIVE, 600, active lines.
- V_FP, 37, vertical front porch, lines.
- V_SYNC, 6, v_sync width, lines.
- V_BP, 23, vertical back porch, lines.
- SYNC_POL, 1, asserted level of both syncs.
- LOCK_FRAMES, 3, consecutive good frames needed to lock.
- Derived: H_TOTAL = 1040, V_TOTAL = 666.

Ports:
- clk_60Mhz  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- i_h_sync  in  1  horizontal sync from the driver.
- i_v_sync  in  1  vertical sync from the driver.
- i_r / i_g / i_b  in  COLOR_W each  colour channels.
- i_err_clr  in  1  clears o_err.
- o_locked  out  1  high while the FSM is in LOCKED.
- o_err  out  5  sticky flags: [0] h_total, [1] h_sync width, [2] v_total, [3] v_sync width, [4] loss of sync.
- o_h_total  out  16  last measured line period, clocks.
- o_v_total  out  16  last measured frame period, lines.
- o_frame_done  out  1  one-cycle pulse when a frame completes.
- o_frame_pix  out  20  active pixels counted in the last frame.
- o_frame_sum  out  32  sum mod 2^32 of the {r,g,b} words over active pixels in the last frame.

Behaviour:
Reset:
- When reset is sampled high, every output and counter is 0 and the FSM goes to SEARCH on the next edge.
- Reset mid-frame discards all partial measurements.

Events:
- h_rise: i_h_sync goes to SYNC_POL while its registered copy is deasserted. Detection uses the input and one register stage.
- v_sync is sampled only at h_rise. frame_start = h_rise with v asserted, where v was deasserted at the previous h_rise.

Counters:
- h_pos = 0 in the h_rise cycle, otherwise previous value + 1, saturating at 0xFFFF.
- At h_rise: line_period = previous h_pos + 1, which updates o_h_total.
- h_sync width = clocks with the sync asserted, latched on deassertion.
- v_line = 0 at frame_start, +1 at each other h_rise.
- v_sync width = number of h_rise events with v asserted.
- At frame_start: o_v_total = previous v_line + 1.

Active region and checksum:
- A pixel is active when H_SYNC+H_BP <= h_pos < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= v_line < V_SYNC+V_BP+V_ACTIVE.
- Each active cycle adds 1 to the pixel counter and the pixel word to the sum accumulator. The sum wraps mod 2^32.
- At frame_start, the accumulators transfer to o_frame_pix and o_frame_sum and then restart from 0.
- o_frame_done pulses the cycle after frame_start, only when the FSM is not in SEARCH and the frame is not the first partial one.

Frame good:
- Every line has period H_TOTAL and h_sync width H_SYNC.
- v_total equals V_TOTAL and v_sync width equals V_SYNC.
- Per-check mismatch bits accumulate across the frame.

FSM:
- SEARCH:
  - Enters TRACK at frame_start with good_cnt = 0.
  - The first frame after entry is partial and is never judged.
- TRACK, at each frame_start:
  - Good frame: good_cnt +1. When good_cnt reaches LOCK_FRAMES, move to LOCKED.
  - Bad frame: good_cnt = 0 and stay in TRACK. o_err is not set.
- LOCKED, at each frame_start:
  - Bad frame: move to TRACK with good_cnt = 0, and OR the mismatch bits into o_err[3:0].
- Timeout: if h_pos reaches 2*H_TOTAL in TRACK or LOCKED, the FSM goes to SEARCH next cycle and sets o_err[4]. o_locked falls that same cycle.

Errors:
- o_err bits clear only when i_err_clr is high.
- If i_err_clr and a set occur in the same cycle, the set wins for that bit.

Decomposition:
- Package vga_timing_pkg holds:
  - the mode constants (H_/V_ values and totals, shared with the driver);
  - the FSM state encoding (SEARCH, TRACK, LOCKED);
  - the error bit indices.
- One sub-module, vga_sync_edge: sync polarity normalisation, rise/fall detection and width counter. It is instantiated once for h and once for v; the v instance is clock-enabled by h_rise.

Test Plan:
1. Ideal default-mode stream for 5 frames -> o_locked rises on the 4th frame_start after the first; o_h_total = 1040; o_v_total = 666; o_err = 0.
2. Active pixels all r=g=b=1 (word 0x111) -> o_frame_pix = 480000, o_frame_sum = 131040000, o_frame_done pulses once per frame.
3. While locked, one line stretched to 1041 clocks -> at the next frame_start o_locked = 0 and o_err = 5'b00001; after 3 further good frames o_locked = 1 again.
4. While locked, h_sync held deasserted -> at h_pos = 2080 the FSM enters SEARCH, o_locked = 0, o_err[4] = 1; relock follows the SEARCH->TRACK sequence once the stream resumes.
5. Reset pulse mid-frame while locked -> all outputs are 0 the following cycle; the first frame_start after reset produces no o_frame_done.
6. i_err_clr asserted in the same cycle that a v_sync width error sets o_err[3] -> o_err[3] remains 1; clearing on a later cycle returns o_err to 0.
